btn_event_gen: RTL and testbench

//  Converts the two synchronized front-panel buttons into debounced levels and

---
 rtl/btn_event_gen.sv | 246 ++++++++++++++++++++++++
 tb/tb_btn_event_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_gen.sv
// -----------------------------------------------------------------------------
// btn_event_gen
//   Turns the two synchronized front-panel buttons into debounced levels and
//   discrete SHORT / LONG / REPEAT events for the CPU controls PIO. The CPU
//   detects a new event by watching btn_code_cnt change. Button 1 is shared
//   with the latency-tester sensor and is muted while lt_active is high.
//
// Ports
//   clk27         in   1  system clock (27 MHz)
//   reset_n       in   1  asynchronous active-low reset
//   btn_in        in   2  raw buttons, active-low, already synchronized to clk27
//   lt_active     in   1  latency tester running; masks button 1
//   btn_level     out  2  debounced pressed state, 1 = pressed
//   btn_code      out  4  last event: [1:0] one-hot button, [3:2] 01 SHORT,
//                         10 LONG, 11 REPEAT
//   btn_evt       out  1  one-cycle strobe when btn_code/btn_code_cnt update
//   btn_code_cnt  out  8  event counter, +1 per event, wraps 255 -> 0
// -----------------------------------------------------------------------------
module btn_event_gen #(
  parameter int unsigned PRESCALE    = 27000, // clk27 cycles per ms tick (2..65535)
  parameter int unsigned DEBOUNCE_MS = 10,    // stable ticks to accept a change (1..255)
  parameter int unsigned LONG_MS     = 1000,  // ticks held before LONG (> DEBOUNCE_MS, <= 4095)
  parameter int unsigned REPEAT_MS   = 200    // ticks between REPEATs (1..4095)
) (
  input  logic       clk27,
  input  logic       reset_n,
  input  logic [1:0] btn_in,
  input  logic       lt_active,
  output logic [1:0] btn_level,
  output logic [3:0] btn_code,
  output logic       btn_evt,
  output logic [7:0] btn_code_cnt
);

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);
  localparam logic [7:0]  DEB_N     = 8'(DEBOUNCE_MS);
  // Thresholds are compared against the count before the increment, so the
  // event fires on the tick that makes the count reach LONG_MS / REPEAT_MS.
  localparam logic [11:0] LONG_TH   = 12'(LONG_MS - 1);
  localparam logic [11:0] REP_TH    = 12'(REPEAT_MS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HELD  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    EV_NONE   = 2'b00,
    EV_SHORT  = 2'b01,
    EV_LONG   = 2'b10,
    EV_REPEAT = 2'b11
  } evt_kind_e;

  typedef struct packed {
    logic      valid;
    evt_kind_e kind;
  } req_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [15:0]      presc_q, presc_d;
  logic             tick;

  logic [1:0]       raw;
  logic [1:0]       raw_prev_q;
  logic [1:0]       lvl_q, lvl_d;
  logic [1:0][7:0]  stable_q, stable_d;
  logic [1:0]       rise, fall;

  state_e [1:0]     state_q, state_d;
  logic [1:0][11:0] hold_q, hold_d;
  req_t [1:0]       req_q, req_d;

  req_t             req1;
  req_t             pend_q, pend_d;
  logic [3:0]       code_q, code_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             evt_q, evt_d;

  // ---------------------------------------------------------------------------
  // Shared 1 ms tick
  // ---------------------------------------------------------------------------
  assign tick = (presc_q == PRESC_MAX);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    presc_d = presc_q + 16'd1;
    if (tick) presc_d = '0;
  end

  // ---------------------------------------------------------------------------
  // Debounce: accept a new level only after DEBOUNCE_MS ticks with no change.
  // The accept also requires no change in the current cycle, otherwise a
  // transition landing on a saturated counter would be accepted undebounced.
  // ---------------------------------------------------------------------------
  assign raw = ~btn_in;

  always_comb begin
    stable_d = stable_q;
    lvl_d    = lvl_q;
    rise     = '0;
    fall     = '0;
    for (int i = 0; i < 2; i++) begin
      if (raw[i] != raw_prev_q[i]) begin
        stable_d[i] = '0;
      end else if (tick && (stable_q[i] != DEB_N)) begin
        stable_d[i] = stable_q[i] + 8'd1;
      end

      if ((stable_q[i] == DEB_N) && (raw[i] == raw_prev_q[i]) &&
          (raw[i] != lvl_q[i])) begin
        lvl_d[i] = raw[i];
        rise[i]  = raw[i];
        fall[i]  = ~raw[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event FSMs. They follow the debouncer's own edges rather than the masked
  // btn_level, so dropping lt_active while button 1 is held does not look like
  // a fresh press.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    req_d   = '0;
    for (int i = 0; i < 2; i++) begin
      unique case (state_q[i])
        ST_IDLE: begin
          if (rise[i]) begin
            state_d[i] = ST_PRESS;
            hold_d[i]  = '0;
          end
        end
        ST_PRESS: begin
          // Release is checked first so it wins over a coincident threshold.
          if (fall[i]) begin
            req_d[i]   = '{valid: 1'b1, kind: EV_SHORT};
            state_d[i] = ST_IDLE;
          end else if (tick) begin
            if (hold_q[i] == LONG_TH) begin
              req_d[i]   = '{valid: 1'b1, kind: EV_LONG};
              hold_d[i]  = '0;
              state_d[i] = ST_HELD;
            end else begin
              hold_d[i] = hold_q[i] + 12'd1;
            end
          end
        end
        ST_HELD: begin
          if (fall[i]) begin
            state_d[i] = ST_IDLE;
          end else if (tick) begin
            if (hold_q[i] == REP_TH) begin
              req_d[i]  = '{valid: 1'b1, kind: EV_REPEAT};
              hold_d[i] = '0;
            end else begin
              hold_d[i] = hold_q[i] + 12'd1;
            end
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end

    if (lt_active) begin
      state_d[1] = ST_IDLE;
      hold_d[1]  = '0;
      req_d[1]   = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Event output: button 0 first, button 1 parked in the pending slot when
  // both request together. Anything from button 1 is dropped under lt_active.
  // ---------------------------------------------------------------------------
  assign req1 = lt_active ? '0 : req_q[1];

  always_comb begin
    code_d = code_q;
    cnt_d  = cnt_q;
    evt_d  = 1'b0;
    pend_d = pend_q;

    if (req_q[0].valid) begin
      code_d = {req_q[0].kind, 2'b01};
      cnt_d  = cnt_q + 8'd1;
      evt_d  = 1'b1;
      if (req1.valid) pend_d = req1;
    end else if (pend_q.valid && !lt_active) begin
      code_d = {pend_q.kind, 2'b10};
      cnt_d  = cnt_q + 8'd1;
      evt_d  = 1'b1;
      pend_d = req1;
    end else if (req1.valid) begin
      code_d = {req1.kind, 2'b10};
      cnt_d  = cnt_q + 8'd1;
      evt_d  = 1'b1;
    end

    if (lt_active) pend_d = '0;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= '0;
      raw_prev_q <= '0;
      lvl_q      <= '0;
      stable_q   <= '0;
      state_q    <= {ST_IDLE, ST_IDLE};
      hold_q     <= '0;
      req_q      <= '0;
      pend_q     <= '0;
      code_q     <= '0;
      cnt_q      <= '0;
      evt_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      raw_prev_q <= raw;
      lvl_q      <= lvl_d;
      stable_q   <= stable_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      req_q      <= req_d;
      pend_q     <= pend_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      evt_q      <= evt_d;
    end
  end

  assign btn_level    = {lvl_q[1] & ~lt_active, lvl_q[0]};
  assign btn_code     = code_q;
  assign btn_evt      = evt_q;
  assign btn_code_cnt = cnt_q;

endmodule

// File: tb/tb_btn_event_gen.sv
// -----------------------------------------------------------------------------
// tb_btn_event_gen
//   Directed bench for btn_event_gen with PRESCALE=4 (tick every 4 clocks),
//   DEBOUNCE_MS=3, LONG_MS=20, REPEAT_MS=5. Every strobe of btn_evt is logged
//   with its code, counter value and cycle number; each test then compares
//   the new log entries against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_btn_event_gen;

  logic       clk27 = 1'b0;
  logic       reset_n;
  logic [1:0] btn_in;
  logic       lt_active;
  logic [1:0] btn_level;
  logic [3:0] btn_code;
  logic       btn_evt;
  logic [7:0] btn_code_cnt;

  btn_event_gen #(
    .PRESCALE   (4),
    .DEBOUNCE_MS(3),
    .LONG_MS    (20),
    .REPEAT_MS  (5)
  ) dut (
    .clk27       (clk27),
    .reset_n     (reset_n),
    .btn_in      (btn_in),
    .lt_active   (lt_active),
    .btn_level   (btn_level),
    .btn_code    (btn_code),
    .btn_evt     (btn_evt),
    .btn_code_cnt(btn_code_cnt)
  );

  always #5 clk27 = ~clk27;

  localparam logic [3:0] C_SHORT0  = 4'b0101;
  localparam logic [3:0] C_LONG0   = 4'b1001;
  localparam logic [3:0] C_REPEAT0 = 4'b1101;
  localparam logic [3:0] C_SHORT1  = 4'b0110;

  typedef struct {
    logic [3:0] code;
    logic [7:0] cnt;
    int         cyc;
  } evt_rec_t;

  evt_rec_t   evq[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [1:0] lvl_or;

  always @(posedge clk27) cyc <= cyc + 1;

  always @(negedge clk27) begin
    if (reset_n && btn_evt) evq.push_back('{btn_code, btn_code_cnt, cyc});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance n clocks from a drive point, OR-ing btn_level into lvl_or.
  task automatic hold_sample(input int n);
    repeat (n) begin
      @(negedge clk27);
      lvl_or = lvl_or | btn_level;
    end
    @(posedge clk27);
    #1;
  endtask

  task automatic wait_level(input int idx, input logic val, input int budget,
                            input string tag, output int at_cyc);
    bit hit = 1'b0;
    at_cyc = -1;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge clk27);
      if (btn_level[idx] === val) begin
        hit    = 1'b1;
        at_cyc = cyc;
      end
    end
    check(tag, 32'(hit), 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_level"}, 32'(btn_level), 0);
    check({tag, "_code"},  32'(btn_code), 0);
    check({tag, "_evt"},   32'(btn_evt), 0);
    check({tag, "_cnt"},   32'(btn_code_cnt), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, t_rise, t_dummy, bad;
    bit hit;

    btn_in    = 2'b11;
    lt_active = 1'b0;
    reset_n   = 1'b0;
    lvl_or    = '0;
    #3;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk27);
    #1;
    reset_n = 1'b1;
    hold_sample(2);

    // 1: long hold -> LONG then four REPEATs, nothing on release.
    base = evq.size();
    btn_in[0] = 1'b0;
    wait_level(0, 1'b1, 16, "t1_level_rise", t_rise);
    repeat (160) @(posedge clk27);
    #1;
    btn_in[0] = 1'b1;
    wait_level(0, 1'b0, 16, "t1_level_fall", t_dummy);
    hold_sample(40);
    check("t1_evt_count", 32'(evq.size() - base), 5);
    if (evq.size() - base == 5) begin
      for (int k = 0; k < 5; k++) begin
        check($sformatf("t1_code%0d", k), 32'(evq[base+k].code), (k == 0) ? C_LONG0 : C_REPEAT0);
        check($sformatf("t1_cnt%0d", k), 32'(evq[base+k].cnt), k + 1);
      end
      // rise edge R, first tick R+3, 20th tick R+79, emitted at R+80
      check("t1_long_latency", 32'(evq[base].cyc - t_rise), 80);
      for (int k = 1; k < 5; k++)
        check($sformatf("t1_repeat_gap%0d", k), 32'(evq[base+k].cyc - evq[base+k-1].cyc), 20);
    end
    check("t1_cnt_final", 32'(btn_code_cnt), 5);

    // 2: short press -> exactly one SHORT.
    base = evq.size();
    btn_in[0] = 1'b0;
    hold_sample(32);
    btn_in[0] = 1'b1;
    hold_sample(60);
    check("t2_evt_count", 32'(evq.size() - base), 1);
    check("t2_code", 32'(btn_code), C_SHORT0);
    check("t2_cnt", 32'(btn_code_cnt), 6);
    check("t2_evt_idle", 32'(btn_evt), 0);

    // 3: glitches shorter than the debounce window.
    base   = evq.size();
    lvl_or = '0;
    btn_in[0] = 1'b0;
    hold_sample(4);
    btn_in[0] = 1'b1;
    hold_sample(12);
    repeat (3) begin
      btn_in[0] = 1'b0;
      hold_sample(8);
      btn_in[0] = 1'b1;
      hold_sample(8);
    end
    hold_sample(20);
    check("t3_level_never", 32'(lvl_or[0]), 0);
    check("t3_evt_count", 32'(evq.size() - base), 0);
    check("t3_cnt", 32'(btn_code_cnt), 6);

    // 4: simultaneous SHORTs -> button 0 then button 1 on consecutive cycles.
    base   = evq.size();
    lvl_or = '0;
    btn_in = 2'b00;
    hold_sample(32);
    btn_in = 2'b11;
    hold_sample(60);
    check("t4_both_pressed", 32'(lvl_or), 2'b11);
    check("t4_evt_count", 32'(evq.size() - base), 2);
    if (evq.size() - base == 2) begin
      check("t4_code0", 32'(evq[base].code), C_SHORT0);
      check("t4_cnt0", 32'(evq[base].cnt), 7);
      check("t4_code1", 32'(evq[base+1].code), C_SHORT1);
      check("t4_cnt1", 32'(evq[base+1].cnt), 8);
      check("t4_back_to_back", 32'(evq[base+1].cyc - evq[base].cyc), 1);
    end

    // 5: button 1 muted by lt_active, no SHORT after unmuting while held.
    base      = evq.size();
    lvl_or    = '0;
    lt_active = 1'b1;
    btn_in[1] = 1'b0;
    hold_sample(120);
    check("t5_level_masked", 32'(lvl_or[1]), 0);
    check("t5_no_evt_masked", 32'(evq.size() - base), 0);
    lt_active = 1'b0;
    hold_sample(8);
    check("t5_level_unmasked", 32'(btn_level[1]), 1);
    btn_in[1] = 1'b1;
    hold_sample(60);
    check("t5_no_evt_release", 32'(evq.size() - base), 0);
    check("t5_cnt", 32'(btn_code_cnt), 8);
    btn_in[1] = 1'b0;
    hold_sample(32);
    btn_in[1] = 1'b1;
    hold_sample(60);
    check("t5_fresh_evt_count", 32'(evq.size() - base), 1);
    check("t5_fresh_code", 32'(btn_code), C_SHORT1);
    check("t5_fresh_cnt", 32'(btn_code_cnt), 9);

    // 6: run the counter up to 255 with REPEATs, then one SHORT wraps it to 0.
    base      = evq.size();
    btn_in[0] = 1'b0;
    hit       = 1'b0;
    for (int n = 0; n < 6000 && !hit; n++) begin
      @(negedge clk27);
      if (btn_code_cnt == 8'd255) hit = 1'b1;
    end
    check("t6_reach_255", 32'(hit), 1);
    @(posedge clk27);
    #1;
    btn_in[0] = 1'b1;
    hold_sample(60);
    check("t6_hold_255", 32'(btn_code_cnt), 255);
    check("t6_code_repeat", 32'(btn_code), C_REPEAT0);
    bad = 0;
    for (int k = base; k < evq.size(); k++)
      if (evq[k].cnt != 8'(10 + k - base)) bad++;
    check("t6_cnt_sequence", 32'(bad), 0);
    btn_in[0] = 1'b0;
    hold_sample(32);
    btn_in[0] = 1'b1;
    hold_sample(60);
    check("t6_wrap_cnt", 32'(btn_code_cnt), 0);
    check("t6_wrap_code", 32'(btn_code), C_SHORT0);

    // Reset mid-HELD: outputs clear asynchronously, then the held button must
    // debounce again before it can produce an event.
    btn_in[0] = 1'b0;
    hit       = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk27);
      if (btn_evt && btn_code == C_LONG0) hit = 1'b1;
    end
    check("t7_reach_held", 32'(hit), 1);
    #1;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("t7_async_reset");
    @(posedge clk27);
    #1;
    reset_n = 1'b1;
    base    = evq.size();
    lvl_or  = '0;
    hold_sample(8);
    check("t7_redebounce", 32'(lvl_or[0]), 0);
    wait_level(0, 1'b1, 16, "t7_level_rise", t_dummy);
    @(posedge clk27);
    #1;
    btn_in[0] = 1'b1;
    hold_sample(60);
    check("t7_evt_count", 32'(evq.size() - base), 1);
    check("t7_code", 32'(btn_code), C_SHORT0);
    check("t7_cnt", 32'(btn_code_cnt), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
